key_button_debounce: RTL and testbench
======================================

Name: key_button_debounce

Overview:
- Upstream conditioning stage for the 12-key button decoder.
- Synchronises the raw 12-bit key vector into clk_1MHz and debounces each key independently.
- Emits a clean, level-stable key vector that drives the decoder's key_button_in directly.
- Also emits per-key one-cycle press/release strobes for game logic that wants edges, not levels.

Parameters:
- N_KEYS, 12, number of independent key lines.
- DEBOUNCE_CYCLES, 10000, consecutive stable cycles required to accept a new level (10 ms at 1 MHz). Must be >= 1.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), derived localparam, counter width. Not overridable.

Ports:
- clk_1MHz  input  1  system clock, 1 MHz.
- rst_n  input  1  reset, asynchronous, active-low.
- enable  input  1  1 = debouncing active; 0 = all outputs forced low, counters cleared.
- key_button_raw  input  N_KEYS  raw asynchronous key levels, 1 = pressed.
- key_button_out  output  N_KEYS  debounced stable levels; feeds the decoder's key_button_in.
- press_pulse  output  N_KEYS  1-cycle strobe when a key's stable level goes 0->1.
- release_pulse  output  N_KEYS  1-cycle strobe when a key's stable level goes 1->0.

Behaviour:
- One clock domain, clk_1MHz. Reset is asynchronous and active-low: rst_n low immediately clears every flop, with no clock needed.
- Reset values: sync stages 0, counters 0, key_button_out 0, press_pulse 0, release_pulse 0.
- Synchroniser: a 2-flop chain per key (s1, s2). s2 is the only version of the raw input used downstream.
- Per-key counter:
  - If s2 == stable: counter <= 0.
  - If s2 != stable and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
  - If s2 != stable and counter == DEBOUNCE_CYCLES-1: stable <= s2, counter <= 0, and the matching strobe asserts for exactly one cycle.
- Bounce handling: any return of s2 to the stable value before acceptance clears the counter and restarts the count. A single-cycle glitch never reaches the output.
- Latency:
  - A raw level held from just before clock edge 0 reaches s2 at edge 1.
  - key_button_out changes at edge 1+DEBOUNCE_CYCLES.
  - DEBOUNCE_CYCLES=1 gives a 2-cycle total latency.
- Strobes:
  - Registered, asserted in the same cycle key_button_out changes, low in the next cycle.
  - press_pulse and release_pulse are never both high for the same key.
- Key independence: no cross-key interaction. Simultaneous acceptance on several keys is allowed, so key_button_out may have multiple bits set; the decoder's default branch handles that case.
- enable low:
  - Synchronous clear of counters, stable levels and strobes on the next edge. No release_pulse is generated for the forced clear.
  - The synchroniser keeps running.
- enable rising: debouncing restarts from stable=0. A key already held is accepted after DEBOUNCE_CYCLES cycles and produces a press_pulse.
- Counter wrap: the counter never exceeds DEBOUNCE_CYCLES-1, so there is no wrap-around.
- Reset mid-count: all state is lost and no strobe fires. After rst_n rises the block behaves as if freshly powered.

Decomposition:
- Shared package key_pkg:
  - N_KEYS_DEFAULT = 12.
  - DEBOUNCE_1MS = 1000 and DEBOUNCE_10MS = 10000 constants.
  - A key_vec_t typedef of width N_KEYS_DEFAULT.
- Sub-module debounce_cell: a single-bit synchroniser, counter and strobe. The top instantiates it N_KEYS times with a generate loop, and the top gates all of them with enable.

Test Plan (DEBOUNCE_CYCLES=4 unless noted):
- Reset: hold rst_n=0 with raw=12'hFFF and toggle clocks -> all outputs 0. Release rst_n while raw is still 12'hFFF -> out=12'hFFF at edge 5 after release, press_pulse=12'hFFF for exactly 1 cycle.
- Clean press: raw bit3 0->1 before edge 0 and held -> out=12'h008 at edge 5, press_pulse=12'h008 for one cycle. Release -> out=0 at +5 edges, release_pulse=12'h008 for one cycle.
- Bounce: bit0 toggles 1,0,1,0 each cycle, then held at 1 -> no output change during bouncing. out bit0=1 exactly 5 edges after the last toggle, with a single press_pulse.
- Glitch rejection: a 1-cycle high on bit11 -> out and press_pulse remain 0 throughout.
- Multi-key and enable: bit1 and bit9 pressed together -> out=12'h202 with both press_pulse bits set in the same cycle. Drop enable -> out=0 next edge and no release_pulse. Raise enable with the keys still held -> out=12'h202 after 4 edges, with press_pulse.
- Reset mid-count: press bit5, assert rst_n=0 at edge 3 -> out stays 0 and no strobe fires. Release rst_n with the key held -> acceptance after a full 5 edges.
- Latency at DEBOUNCE_CYCLES=1: raw bit2 held from before edge 0 -> out change at edge 2.

Source files
------------

// File: rtl/key_pkg.sv
// Shared constants and types for the key-conditioning path.
//   N_KEYS_DEFAULT : width of the key vector feeding the 12-key decoder
//   DEBOUNCE_1MS   : debounce length for 1 ms at 1 MHz
//   DEBOUNCE_10MS  : debounce length for 10 ms at 1 MHz
//   key_vec_t      : one bit per key, 1 = pressed
package key_pkg;

  localparam int N_KEYS_DEFAULT = 12;
  localparam int DEBOUNCE_1MS   = 1000;
  localparam int DEBOUNCE_10MS  = 10000;

  typedef logic [N_KEYS_DEFAULT-1:0] key_vec_t;

endpackage

// File: rtl/debounce_cell.sv
// Single-key conditioner: 2-flop synchroniser, stability counter and
// registered press/release strobes.
// Ports:
//   clk_1MHz      : system clock
//   rst_n         : asynchronous active-low reset, clears every flop
//   enable        : 0 clears counter, stable level and strobes on the next edge
//   key_raw       : raw asynchronous key level, 1 = pressed
//   key_stable    : debounced level
//   press_pulse   : one-cycle strobe on an accepted 0->1 change
//   release_pulse : one-cycle strobe on an accepted 1->0 change
module debounce_cell
  import key_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS
) (
  input  logic clk_1MHz,
  input  logic rst_n,
  input  logic enable,
  input  logic key_raw,
  output logic key_stable,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk_1MHz or negedge rst_n) begin
    if (!rst_n) begin
      s1            <= 1'b0;
      s2            <= 1'b0;
      cnt           <= '0;
      key_stable    <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      // synchroniser stage: keeps running even while disabled
      s1 <= key_raw;
      s2 <= s1;

      // debounce stage
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      if (!enable) begin
        // forced clear is silent: no release strobe
        cnt        <= '0;
        key_stable <= 1'b0;
      end else if (s2 == key_stable) begin
        // any return to the stable level restarts the count
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        key_stable    <= s2;
        cnt           <= '0;
        press_pulse   <= s2;
        release_pulse <= ~s2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/key_button_debounce.sv
// Upstream conditioning for the 12-key button decoder: synchronises the raw
// key vector into clk_1MHz and debounces every key independently.
// Ports:
//   clk_1MHz       : system clock, 1 MHz
//   rst_n          : asynchronous active-low reset
//   enable         : 1 = debouncing active, 0 = outputs forced low
//   key_button_raw : raw asynchronous key levels, 1 = pressed
//   key_button_out : debounced levels, drives the decoder's key_button_in
//   press_pulse    : per-key one-cycle strobe on accepted press
//   release_pulse  : per-key one-cycle strobe on accepted release
module key_button_debounce
  import key_pkg::*;
#(
  parameter int N_KEYS          = N_KEYS_DEFAULT,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS
) (
  input  logic              clk_1MHz,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [N_KEYS-1:0] key_button_raw,
  output logic [N_KEYS-1:0] key_button_out,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse
);

  // Keys are fully independent; several may be accepted in the same cycle.
  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_cell (
      .clk_1MHz     (clk_1MHz),
      .rst_n        (rst_n),
      .enable       (enable),
      .key_raw      (key_button_raw[k]),
      .key_stable   (key_button_out[k]),
      .press_pulse  (press_pulse[k]),
      .release_pulse(release_pulse[k])
    );
  end

endmodule

// File: tb/tb_key_button_debounce.sv
module tb_key_button_debounce;
  import key_pkg::*;

  localparam int D = 4;

  logic     clk_1MHz = 1'b0;
  logic     rst_n    = 1'b0;
  logic     enable   = 1'b1;
  key_vec_t raw      = '0;
  key_vec_t raw1     = '0;
  key_vec_t out, press, rel;
  key_vec_t out1, press1, rel1;

  always #500 clk_1MHz = ~clk_1MHz;

  key_button_debounce #(.N_KEYS(12), .DEBOUNCE_CYCLES(D)) dut (
    .clk_1MHz(clk_1MHz), .rst_n(rst_n), .enable(enable),
    .key_button_raw(raw), .key_button_out(out),
    .press_pulse(press), .release_pulse(rel)
  );

  key_button_debounce #(.N_KEYS(12), .DEBOUNCE_CYCLES(1)) dut1 (
    .clk_1MHz(clk_1MHz), .rst_n(rst_n), .enable(enable),
    .key_button_raw(raw1), .key_button_out(out1),
    .press_pulse(press1), .release_pulse(rel1)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: raw samples pass through a two-edge delay line; a key
  // takes a new level once the last D delayed samples (all taken while
  // enabled) disagree with its current stable level.
  key_vec_t rawd[$];
  key_vec_t win[$];
  key_vec_t m_out, m_press, m_rel;

  task automatic model_reset();
    rawd.delete();
    rawd.push_back('0);
    rawd.push_back('0);
    win.delete();
    m_out   = '0;
    m_press = '0;
    m_rel   = '0;
  endtask

  task automatic model_edge();
    key_vec_t s2;
    bit       all_diff;
    s2 = rawd.pop_front();
    rawd.push_back(raw);
    m_press = '0;
    m_rel   = '0;
    if (!enable) begin
      m_out = '0;
      win.delete();
    end else begin
      win.push_back(s2);
      if (win.size() > D) void'(win.pop_front());
      if (win.size() == D) begin
        for (int b = 0; b < 12; b++) begin
          all_diff = 1'b1;
          foreach (win[i]) if (win[i][b] == m_out[b]) all_diff = 1'b0;
          if (all_diff) begin
            m_out[b] = s2[b];
            if (s2[b]) m_press[b] = 1'b1;
            else       m_rel[b]   = 1'b1;
          end
        end
      end
    end
  endtask

  // Inputs change at the falling edge; results are looked at on the next falling edge.
  task automatic step(input key_vec_t r, input logic en, input logic rn);
    raw    = r;
    enable = en;
    rst_n  = rn;
    if (!rn) model_reset();
    @(posedge clk_1MHz);
    if (rn) model_edge();
    @(negedge clk_1MHz);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      step(12'hFFF, 1'b1, 1'b0);
      n_vec++;
      if ({out, press, rel} !== 36'h0) begin
        n_err++;
        $display("FAIL reset_hold cyc%0d out=%h press=%h rel=%h want all 0", i, out, press, rel);
      end
    end
    for (int i = 0; i < 8; i++) begin
      step(12'hFFF, 1'b1, 1'b1);
      n_vec++;
      if ({out, press, rel} !== {m_out, m_press, m_rel}) begin
        n_err++;
        $display("FAIL reset_release cyc%0d out=%h/%h press=%h/%h rel=%h/%h", i, out, m_out, press, m_press, rel, m_rel);
      end
      if (i == 4 || i == 5 || i == 6) begin
        n_vec++;
        if (out !== (i == 4 ? 12'h000 : 12'hFFF) || press !== (i == 5 ? 12'hFFF : 12'h000)) begin
          n_err++;
          $display("FAIL reset_accept edge%0d out=%h press=%h", i, out, press);
        end
      end
    end
  endtask

  task automatic test_clean_press();
    for (int i = 0; i < 8; i++) begin
      step(12'h000, 1'b1, 1'b1);
      n_vec++;
      if ({out, press, rel} !== {m_out, m_press, m_rel}) begin
        n_err++;
        $display("FAIL release_all cyc%0d out=%h/%h press=%h/%h rel=%h/%h", i, out, m_out, press, m_press, rel, m_rel);
      end
    end
    for (int i = 0; i < 8; i++) begin
      step(12'h008, 1'b1, 1'b1);
      n_vec++;
      if ({out, press, rel} !== {m_out, m_press, m_rel}) begin
        n_err++;
        $display("FAIL press3 cyc%0d out=%h/%h press=%h/%h rel=%h/%h", i, out, m_out, press, m_press, rel, m_rel);
      end
      if (i == 5) begin
        n_vec++;
        if (out !== 12'h008 || press !== 12'h008) begin
          n_err++;
          $display("FAIL press3_edge5 out=%h press=%h want 008/008", out, press);
        end
      end
    end
    for (int i = 0; i < 8; i++) begin
      step(12'h000, 1'b1, 1'b1);
      n_vec++;
      if ({out, press, rel} !== {m_out, m_press, m_rel}) begin
        n_err++;
        $display("FAIL rel3 cyc%0d out=%h/%h press=%h/%h rel=%h/%h", i, out, m_out, press, m_press, rel, m_rel);
      end
      if (i == 5 || i == 6) begin
        n_vec++;
        if (out !== 12'h000 || rel !== (i == 5 ? 12'h008 : 12'h000)) begin
          n_err++;
          $display("FAIL rel3_edge%0d out=%h rel=%h", i, out, rel);
        end
      end
    end
  endtask

  task automatic test_bounce();
    key_vec_t seq [4] = '{12'h001, 12'h000, 12'h001, 12'h000};
    for (int i = 0; i < 4; i++) begin
      step(seq[i], 1'b1, 1'b1);
      n_vec++;
      if (out !== 12'h000 || press !== 12'h000 || {out, press, rel} !== {m_out, m_press, m_rel}) begin
        n_err++;
        $display("FAIL bounce cyc%0d out=%h press=%h want 0", i, out, press);
      end
    end
    for (int j = 0; j < 10; j++) begin
      step(12'h001, 1'b1, 1'b1);
      n_vec++;
      if ({out, press, rel} !== {m_out, m_press, m_rel}) begin
        n_err++;
        $display("FAIL bounce_hold cyc%0d out=%h/%h press=%h/%h rel=%h/%h", j, out, m_out, press, m_press, rel, m_rel);
      end
      n_vec++;
      if (out !== (j >= 5 ? 12'h001 : 12'h000) || press !== (j == 5 ? 12'h001 : 12'h000)) begin
        n_err++;
        $display("FAIL bounce_accept edge%0d out=%h press=%h", j, out, press);
      end
    end
    for (int i = 0; i < 7; i++) step(12'h000, 1'b1, 1'b1);
  endtask

  task automatic test_glitch();
    for (int i = 0; i < 9; i++) begin
      step(i == 0 ? 12'h800 : 12'h000, 1'b1, 1'b1);
      n_vec++;
      if (out !== 12'h000 || press !== 12'h000 || {out, press, rel} !== {m_out, m_press, m_rel}) begin
        n_err++;
        $display("FAIL glitch cyc%0d out=%h press=%h want 0", i, out, press);
      end
    end
  endtask

  task automatic test_multi_enable();
    for (int i = 0; i < 8; i++) begin
      step(12'h202, 1'b1, 1'b1);
      n_vec++;
      if ({out, press, rel} !== {m_out, m_press, m_rel}) begin
        n_err++;
        $display("FAIL multi cyc%0d out=%h/%h press=%h/%h rel=%h/%h", i, out, m_out, press, m_press, rel, m_rel);
      end
      if (i == 5) begin
        n_vec++;
        if (out !== 12'h202 || press !== 12'h202) begin
          n_err++;
          $display("FAIL multi_edge5 out=%h press=%h want 202/202", out, press);
        end
      end
    end
    for (int i = 0; i < 3; i++) begin
      step(12'h202, 1'b0, 1'b1);
      n_vec++;
      if ({out, press, rel} !== 36'h0) begin
        n_err++;
        $display("FAIL disable cyc%0d out=%h press=%h rel=%h want all 0", i, out, press, rel);
      end
    end
    for (int i = 0; i < 6; i++) begin
      step(12'h202, 1'b1, 1'b1);
      n_vec++;
      if ({out, press, rel} !== {m_out, m_press, m_rel}) begin
        n_err++;
        $display("FAIL reenable cyc%0d out=%h/%h press=%h/%h rel=%h/%h", i, out, m_out, press, m_press, rel, m_rel);
      end
      n_vec++;
      if (out !== (i >= 3 ? 12'h202 : 12'h000) || press !== (i == 3 ? 12'h202 : 12'h000)) begin
        n_err++;
        $display("FAIL reenable_accept edge%0d out=%h press=%h", i, out, press);
      end
    end
    for (int i = 0; i < 7; i++) step(12'h000, 1'b1, 1'b1);
  endtask

  task automatic test_reset_midcount();
    for (int i = 0; i < 3; i++) step(12'h020, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      step(12'h020, 1'b1, 1'b0);
      n_vec++;
      if ({out, press, rel} !== 36'h0) begin
        n_err++;
        $display("FAIL midreset cyc%0d out=%h press=%h rel=%h want all 0", i, out, press, rel);
      end
    end
    for (int i = 0; i < 8; i++) begin
      step(12'h020, 1'b1, 1'b1);
      n_vec++;
      if ({out, press, rel} !== {m_out, m_press, m_rel}) begin
        n_err++;
        $display("FAIL postreset cyc%0d out=%h/%h press=%h/%h rel=%h/%h", i, out, m_out, press, m_press, rel, m_rel);
      end
      n_vec++;
      if (out !== (i >= 5 ? 12'h020 : 12'h000) || press !== (i == 5 ? 12'h020 : 12'h000)) begin
        n_err++;
        $display("FAIL postreset_accept edge%0d out=%h press=%h", i, out, press);
      end
    end
  endtask

  task automatic test_random();
    key_vec_t cur = '0;
    logic     en;
    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < 12; b++)
        if ($urandom_range(0, 5) == 0) cur[b] = ~cur[b];
      en = ($urandom_range(0, 39) != 0);
      step(cur, en, 1'b1);
      n_vec++;
      if ({out, press, rel} !== {m_out, m_press, m_rel}) begin
        n_err++;
        $display("FAIL random cyc%0d out=%h/%h press=%h/%h rel=%h/%h", i, out, m_out, press, m_press, rel, m_rel);
      end
    end
  endtask

  task automatic test_latency_d1();
    raw1 = '0;
    step(12'h000, 1'b1, 1'b0);
    step(12'h000, 1'b1, 1'b0);
    raw1 = 12'h004;
    for (int i = 0; i < 4; i++) begin
      step(12'h000, 1'b1, 1'b1);
      n_vec++;
      if (out1 !== (i >= 2 ? 12'h004 : 12'h000) || press1 !== (i == 2 ? 12'h004 : 12'h000) || rel1 !== 12'h000) begin
        n_err++;
        $display("FAIL latency_d1 edge%0d out=%h press=%h rel=%h", i, out1, press1, rel1);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_multi_enable();
    test_reset_midcount();
    test_random();
    test_latency_d1();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
